// File: rtl/round_sequencer.sv
// Purpose : runs a multi-round reaction-time session against an external core,
//           kicking each round, collecting results and reporting best/average/misses.
// Ports   : i_clk/i_rst (async active-high), i_start/i_abort session control,
//           i_dst/i_measured core status and result, o_kick core button pulse,
//           o_busy/o_done/o_err status, o_round/o_misses/o_best/o_avg results.
module round_sequencer #(
    parameter int ROUNDS     = 4,
    parameter int GAP_CYCLES = 1000,
    parameter int KICK_TO    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [2:0]  i_dst,
    input  logic [18:0] i_measured,
    output logic        o_kick,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_round,
    output logic [3:0]  o_misses,
    output logic [18:0] o_best,
    output logic [18:0] o_avg
);

    localparam int          LG   = $clog2(ROUNDS);
    localparam int          GW   = $clog2(GAP_CYCLES + 1);
    localparam int          AW   = $clog2(KICK_TO + 1);
    localparam logic [18:0] MAXT = 19'h7FFFF;

    localparam logic [2:0] DST_IDLE  = 3'b000;
    localparam logic [2:0] DST_WAIT  = 3'b001;
    localparam logic [2:0] DST_LIT   = 3'b010;
    localparam logic [2:0] DST_EARLY = 3'b011;
    localparam logic [2:0] DST_FIN   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_KICK, S_ARM, S_RUN, S_DRAIN, S_GAP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            start_q;
    logic [2:0]      prev_dst_q;
    logic [1:0]      retry_q;
    logic [AW-1:0]   arm_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [21:0]     sum_q;
    logic            kick_q, busy_q, done_q, err_q;
    logic [2:0]      round_q;
    logic [3:0]      misses_q;
    logic [18:0]     best_q, avg_q;

    logic start_edge, abort_now, dst_valid, core_active;
    logic arm_expired, hit_ev, miss_ev, drain_done, gap_done, last_round;

    assign start_edge  = i_start & ~start_q;
    assign abort_now   = i_abort & (state_q != S_IDLE);
    // Unlisted status codes are treated as if nothing happened.
    assign dst_valid   = (i_dst == DST_IDLE) | (i_dst == DST_WAIT) | (i_dst == DST_LIT) |
                         (i_dst == DST_EARLY) | (i_dst == DST_FIN);
    assign core_active = dst_valid & (i_dst != DST_IDLE);
    assign arm_expired = (state_q == S_ARM) & ~core_active & (arm_cnt_q == AW'(KICK_TO - 1));
    assign hit_ev      = (state_q == S_RUN) & (i_dst == DST_FIN);
    // Early press, or the core timing out straight from lit back to idle.
    assign miss_ev     = (state_q == S_RUN) &
                         ((i_dst == DST_EARLY) | ((i_dst == DST_IDLE) & (prev_dst_q == DST_LIT)));
    assign drain_done  = (state_q == S_DRAIN) & (i_dst == DST_IDLE);
    assign gap_done    = (state_q == S_GAP) & (gap_cnt_q == '0);
    assign last_round  = (round_q == 3'(ROUNDS - 1));

    always_comb begin
        state_d = state_q;
        if (abort_now) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_edge) state_d = S_CLEAR;
                S_CLEAR:        state_d = S_KICK;
                S_KICK:         state_d = S_ARM;
                S_ARM: begin
                    if (core_active)      state_d = S_RUN;
                    else if (arm_expired) state_d = (retry_q < 2'd2) ? S_KICK : S_IDLE;
                end
                S_RUN:          if (hit_ev | miss_ev) state_d = S_DRAIN;
                S_DRAIN:        if (drain_done) state_d = last_round ? S_DONE : S_GAP;
                S_GAP:          if (gap_done) state_d = S_KICK;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            prev_dst_q <= DST_IDLE;
            retry_q    <= '0;
            arm_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sum_q      <= '0;
            kick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            round_q    <= '0;
            misses_q   <= '0;
            best_q     <= MAXT;
            avg_q      <= MAXT;
        end else begin
            state_q <= state_d;
            start_q <= i_start;
            if (dst_valid) prev_dst_q <= i_dst;

            // Status outputs are registered from the next state so they line up with it.
            kick_q <= (state_d == S_KICK);
            busy_q <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q <= (state_d == S_DONE);

            // Abort freezes every accumulator and counter on the cycle it is seen.
            if (!abort_now) begin
                if (state_d == S_CLEAR) begin
                    sum_q    <= '0;
                    best_q   <= MAXT;
                    misses_q <= '0;
                    round_q  <= '0;
                    err_q    <= 1'b0;
                    retry_q  <= '0;
                end

                if (state_d == S_KICK)      arm_cnt_q <= '0;
                else if (state_q == S_ARM)  arm_cnt_q <= arm_cnt_q + 1'b1;

                if (arm_expired && !core_active) begin
                    if (retry_q < 2'd2) retry_q <= retry_q + 1'b1;
                    else                err_q   <= 1'b1;
                end

                // RUN is left on the event, so each round accumulates exactly once.
                if (hit_ev) begin
                    sum_q <= sum_q + {3'b000, i_measured};
                    if (i_measured < best_q) best_q <= i_measured;
                end
                if (miss_ev) begin
                    sum_q    <= sum_q + {3'b000, MAXT};
                    misses_q <= misses_q + 1'b1;
                end

                if (drain_done && !last_round) begin
                    round_q   <= round_q + 1'b1;
                    retry_q   <= '0;
                    gap_cnt_q <= GW'(GAP_CYCLES - 1);
                end
                if ((state_q == S_GAP) && (gap_cnt_q != '0)) gap_cnt_q <= gap_cnt_q - 1'b1;

                if ((state_d == S_DONE) && (state_q != S_DONE)) avg_q <= sum_q[LG +: 19];
            end
        end
    end

    assign o_kick   = kick_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_round  = round_q;
    assign o_misses = misses_q;
    assign o_best   = best_q;
    assign o_avg    = avg_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Purpose : directed self-checking bench for round_sequencer with short gap/kick timeouts.
// Latency : inputs driven #1 after the rising edge, outputs sampled at the same point.
// Flow    : a scripted core model answers each kick; no backpressure involved.
module tb_round_sequencer;

    localparam int RND = 4;
    localparam int GAP = 5;
    localparam int KTO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [2:0]  i_dst = 3'b000;
    logic [18:0] i_measured = '0;
    logic        o_kick, o_busy, o_done, o_err;
    logic [2:0]  o_round;
    logic [3:0]  o_misses;
    logic [18:0] o_best, o_avg;

    int n_checks = 0;
    int n_pass   = 0;

    round_sequencer #(.ROUNDS(RND), .GAP_CYCLES(GAP), .KICK_TO(KTO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_dst(i_dst), .i_measured(i_measured),
        .o_kick(o_kick), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_round(o_round), .o_misses(o_misses), .o_best(o_best), .o_avg(o_avg)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_kick(input int exp_round);
        int found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (o_kick) found = 1;
        end
        chk("kick_seen", 32'(found), 32'd1);
        chk("kick_round", 32'(o_round), 32'(exp_round));
    endtask

    // Core model for one round, starting in the kick cycle. code 000 = core timeout.
    task automatic play_round(input logic [2:0] code, input int meas, input bit ps);
        i_dst = 3'b001;
        tick(); tick();
        if (ps) begin
            pulse_start();
            tick();
            chk("busy_start_no_kick", 32'(o_kick), 32'd0);
            chk("busy_start_busy", 32'(o_busy), 32'd1);
        end
        i_dst = 3'b010;
        tick(); tick();
        if (code != 3'b000) begin
            i_dst = code;
            i_measured = 19'(meas);
            repeat (3) tick();
        end
        i_dst = 3'b000;
        tick();
        if (code == 3'b000) tick();
        i_measured = '0;
    endtask

    task automatic chk_results(input string tag, input int done, input int best, input int avg,
                               input int misses);
        chk({tag, "_done"}, 32'(o_done), 32'(done));
        chk({tag, "_best"}, 32'(o_best), 32'(best));
        chk({tag, "_avg"}, 32'(o_avg), 32'(avg));
        chk({tag, "_misses"}, 32'(o_misses), 32'(misses));
    endtask

    initial begin
        int n, found, kicks;

        // Reset state
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        chk("rst_kick", 32'(o_kick), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_round", 32'(o_round), 32'd0);
        chk_results("rst", 0, 19'h7FFFF, 19'h7FFFF, 0);

        // Four hits 100..400: best 100, avg 1000/4 = 250
        pulse_start();
        chk("start_busy", 32'(o_busy), 32'd1);
        for (int r = 0; r < RND; r++) begin
            wait_kick(r);
            play_round(3'b110, (r + 1) * 100, 1'b0);
        end
        chk_results("hits", 1, 100, 250, 0);
        chk("hits_busy", 32'(o_busy), 32'd0);

        // Round 2 early, others 1000: avg (3000 + 524287) >> 2 = 131821
        pulse_start();
        for (int r = 0; r < RND; r++) begin
            wait_kick(r);
            play_round((r == 2) ? 3'b011 : 3'b110, 1000, 1'b0);
        end
        chk_results("early", 1, 1000, 131821, 1);

        // Finish held for 50 cycles: accumulated once; kick GAP cycles after the return
        pulse_start();
        wait_kick(0);
        i_dst = 3'b001; tick(); tick();
        i_dst = 3'b010; tick(); tick();
        i_dst = 3'b110; i_measured = 19'd500;
        repeat (50) tick();
        i_dst = 3'b000; i_measured = '0;
        n = 0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            n++;
            if (o_kick) found = 1;
        end
        chk("gap_kick_seen", 32'(found), 32'd1);
        // The first edge registers the return; the kick follows GAP cycles later.
        chk("gap_len", 32'(n - 1), 32'(GAP));
        chk("gap_round", 32'(o_round), 32'd1);
        play_round(3'b110, 500, 1'b0);
        for (int r = 2; r < RND; r++) begin
            wait_kick(r);
            play_round(3'b110, 500, 1'b0);
        end
        chk_results("hold", 1, 500, 500, 0);

        // Start during RUN ignored; abort in the gap before round 1
        pulse_start();
        wait_kick(0);
        play_round(3'b110, 150, 1'b1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk_results("abort", 0, 150, 500, 0);
        kicks = 0;
        repeat (10) begin tick(); kicks += int'(o_kick); end
        chk("abort_no_kick", 32'(kicks), 32'd0);

        // Core never leaves idle: three kicks KTO+1 apart, then error and idle
        pulse_start();
        wait_kick(0);
        for (int k = 1; k < 3; k++) begin
            n = 0; found = 0;
            for (int i = 0; i < 40 && found == 0; i++) begin
                tick();
                n++;
                if (o_kick) found = 1;
            end
            chk("retry_spacing", 32'(n), 32'(KTO + 1));
        end
        kicks = 0;
        repeat (KTO + 1) begin tick(); kicks += int'(o_kick); end
        chk("retry_no_4th_kick", 32'(kicks), 32'd0);
        chk("retry_err", 32'(o_err), 32'd1);
        chk("retry_busy", 32'(o_busy), 32'd0);
        pulse_start();
        chk("err_cleared", 32'(o_err), 32'd0);
        chk("err_clear_busy", 32'(o_busy), 32'd1);

        // Reset pulsed mid-RUN of round 1
        wait_kick(0);
        play_round(3'b110, 300, 1'b0);
        wait_kick(1);
        i_dst = 3'b001; tick(); tick();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_round", 32'(o_round), 32'd0);
        chk("mid_rst_kick", 32'(o_kick), 32'd0);
        chk_results("mid_rst", 0, 19'h7FFFF, 19'h7FFFF, 0);
        i_dst = 3'b000;
        tick();
        i_rst = 1'b0;
        kicks = 0;
        repeat (20) begin tick(); kicks += int'(o_kick); end
        chk("post_rst_no_kick", 32'(kicks), 32'd0);

        // Round 0 core timeout (lit straight to idle), others hit 200
        // avg (600 + 524287) >> 2 = 131221
        pulse_start();
        for (int r = 0; r < RND; r++) begin
            wait_kick(r);
            play_round((r == 0) ? 3'b000 : 3'b110, 200, 1'b0);
        end
        chk_results("timeout", 1, 200, 131221, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter ROUNDS, default 4: rounds per session; SHALL be a power of two, 2..8.
REQ-002 Parameter GAP_CYCLES, default 1000: idle cycles inserted between rounds, minimum 1.
REQ-003 Parameter KICK_TO, default 16: cycles to wait for the core to leave IDLE after a kick.
REQ-004 i_clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_start  in  1  level; its rising edge (sampled against a registered copy) starts a session.
REQ-007 i_abort  in  1  level; when high in any non-IDLE state, the block SHALL go to IDLE on the next edge.
REQ-008 i_dst  in  3  core status code: 000 idle, 001 wait, 010 lit/measure, 011 early, 110 finish.
REQ-009 i_measured  in  19  core result; valid while i_dst==110.
REQ-010 o_kick  out  1  one-cycle pulse, OR'd externally into the core button input.
REQ-011 o_busy  out  1  high in every state except IDLE and DONE.
REQ-012 o_done  out  1  high only in DONE.
REQ-013 o_err  out  1  sticky; set on kick failure; cleared when a session starts.
REQ-014 o_round  out  3  index of the current round, 0-based.
REQ-015 o_misses  out  4  count of early plus timed-out rounds in the session.
REQ-016 o_best  out  19  minimum hit time; 19'h7FFFF if there are no hits.
REQ-017 o_avg  out  19  session sum >> log2(ROUNDS); a miss contributes 19'h7FFFF to the sum.

Function
REQ-018 States: IDLE, CLEAR, KICK, ARM, RUN, DRAIN, GAP, DONE.
REQ-019 IDLE/DONE: on a start edge, go to CLEAR.
REQ-020 CLEAR (1 cycle): set sum=0, best=7FFFF, misses=0, round=0, err=0, retry=0; go to KICK.
REQ-021 KICK (1 cycle): o_kick=1 and clear the ARM timer; go to ARM.
REQ-022 ARM, i_dst!=000: go to RUN.
REQ-023 ARM, i_dst==000 for KICK_TO cycles:
- retry<2: retry+1, go to KICK.
- otherwise: set o_err and go to IDLE.
REQ-024 RUN, i_dst becomes 110 (first cycle): add i_measured to sum; best=min(best,i_measured); go to DRAIN.
REQ-025 RUN, i_dst becomes 011: add 7FFFF to sum; misses+1; go to DRAIN.
REQ-026 RUN, i_dst goes 010->000 directly (core timeout): treat as a miss; go to DRAIN.
REQ-027 Each round SHALL update sum, best and misses exactly once, even if i_dst holds 110/011 for many cycles.
REQ-028 DRAIN: wait for i_dst==000, then:
- round==ROUNDS-1: go to DONE;
- otherwise: round+1, retry=0, load the gap counter, go to GAP.
REQ-029 GAP: count GAP_CYCLES cycles, then go to KICK.
REQ-030 Sum register SHALL be 22 bits and SHALL never overflow (8 x 7FFFF < 2^22).
REQ-031 o_avg SHALL be the registered sum[18+log2(ROUNDS):log2(ROUNDS)], updated on entry to DONE.
REQ-032 Results SHALL hold in DONE and IDLE until the next CLEAR.
REQ-033 Abort SHALL leave o_best, o_avg and o_misses unchanged and o_done=0.
REQ-034 A start edge while busy SHALL be ignored.
REQ-035 Abort and a same-cycle result event: abort wins; the accumulators SHALL NOT update.
REQ-036 i_dst codes not listed in REQ-008 SHALL be ignored in every state.

Reset
REQ-037 Asserting i_rst SHALL force IDLE asynchronously, at any time including mid-round.
REQ-038 Reset values:
- o_kick=0, o_busy=0, o_done=0, o_err=0;
- o_round=0, o_misses=0;
- o_best=7FFFF, o_avg=7FFFF;
- sum=0, start-edge register=0.
REQ-039 After i_rst is released, no kick SHALL occur until a new start edge.

Verification
REQ-040 ROUNDS=4, four hits of 100/200/300/400 -> o_done=1, o_best=100, o_avg=250, o_misses=0.
REQ-041 Round 2 early (011), others hit 1000 -> o_misses=1, o_best=1000, o_avg=(3000+524287)>>2=131821.
REQ-042 Core held at i_dst=000 -> three o_kick pulses KICK_TO+1 cycles apart, then o_err=1 and IDLE; the next start clears o_err.
REQ-043 i_dst held at 110 for 50 cycles -> sum updated once; the next o_kick is exactly GAP_CYCLES cycles after i_dst returns to 000.
REQ-044 i_abort in GAP of round 1 -> IDLE next cycle, o_done=0, o_best retains its round-0 value; a start edge during RUN has no effect.
REQ-045 i_rst pulsed mid-RUN -> all outputs at reset values immediately; no o_kick after release until a start edge.
